// File: rtl/hp_fifo_n_if.sv
// Host/parasite data FIFO bus bundle: host write strobe, parasite read strobe,
// mode/flush controls and the FIFO status returned to both sides.
interface hp_fifo_n_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH + 1);

  logic             h_selectData;
  logic             h_we_b;
  logic [WIDTH-1:0] h_data;
  logic             p_selectData;
  logic             p_rdnw;
  logic             one_byte_mode;
  logic             flush;
  logic [WIDTH-1:0] p_data;
  logic             p_data_available;
  logic             p_burst_available;
  logic             h_full;
  logic [LW-1:0]    level;
  logic             h_overflow;
  logic             p_underflow;

  modport master (
    output h_selectData, h_we_b, h_data, p_selectData, p_rdnw,
           one_byte_mode, flush,
    input  p_data, p_data_available, p_burst_available, h_full, level,
           h_overflow, p_underflow
  );

  modport slave (
    input  h_selectData, h_we_b, h_data, p_selectData, p_rdnw,
           one_byte_mode, flush,
    output p_data, p_data_available, p_burst_available, h_full, level,
           h_overflow, p_underflow
  );
endinterface

// File: rtl/hp_fifo_n.sv
// Parametrised host-to-parasite Tube data FIFO with burst-mode flag hysteresis,
// one-byte latch mode, flush, fill level and sticky overflow/underflow flags.
module hp_fifo_n #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int BURST = 2
) (
  input  logic        phi2,
  input  logic        rst,
  hp_fifo_n_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] BURST_L  = LW'(BURST);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_prev;
  logic [LW-1:0]    count, count_next;
  logic             avail_q, full_q, overflow_q, underflow_q;
  logic             wr_req, rd_req, push, pop, overwrite;
  logic             not_empty, data_avail, full;

  always_comb begin
    wr_req     = bus.h_selectData & ~bus.h_we_b;
    rd_req     = bus.p_selectData & bus.p_rdnw;
    not_empty  = (count != '0);
    data_avail = bus.one_byte_mode ? not_empty : avail_q;
    full       = bus.one_byte_mode ? not_empty : full_q;
    push       = wr_req & ~full;
    // In one-byte mode a blocked write replaces the newest entry instead of overflowing.
    overwrite  = wr_req & bus.one_byte_mode & not_empty;
    pop        = rd_req & data_avail;
    wr_prev    = (wr_ptr == '0) ? LAST_PTR : wr_ptr - PW'(1);
    count_next = count;
    if (push && !pop)
      count_next = count + LW'(1);
    else if (pop && !push)
      count_next = count - LW'(1);
  end

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      mem         <= '{default: '0};
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      avail_q     <= 1'b0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      mem         <= '{default: '0};
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      avail_q     <= 1'b0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.h_data;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end else if (overwrite) begin
        mem[wr_prev] <= bus.h_data;
      end
      if (pop)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      count <= count_next;
      // Burst flags hold until drained; tracked in both modes for seamless switching.
      if (count_next >= BURST_L)
        avail_q <= 1'b1;
      else if (count_next == '0)
        avail_q <= 1'b0;
      if (count_next == DEPTH_L)
        full_q <= 1'b1;
      else if (count_next == '0)
        full_q <= 1'b0;
      if (wr_req && !push && !overwrite)
        overflow_q <= 1'b1;
      if (rd_req && !data_avail)
        underflow_q <= 1'b1;
    end
  end

  assign bus.p_data            = mem[rd_ptr];
  assign bus.p_data_available  = data_avail;
  assign bus.h_full            = full;
  assign bus.p_burst_available = ~bus.one_byte_mode & (count >= BURST_L);
  assign bus.level             = count;
  assign bus.h_overflow        = overflow_q;
  assign bus.p_underflow       = underflow_q;
endmodule

// File: tb/tb_hp_fifo_n.sv
// Directed self-checking bench for hp_fifo_n at WIDTH=8, DEPTH=4, BURST=2.
module tb_hp_fifo_n;
  logic phi2 = 1'b0;
  logic rst  = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 phi2 = ~phi2;

  hp_fifo_n_if #(.WIDTH(8), .DEPTH(4)) bus ();

  hp_fifo_n #(.WIDTH(8), .DEPTH(4), .BURST(2)) dut (
    .phi2 (phi2),
    .rst  (rst),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: strobes presented for exactly one rising edge, then sampled 1ns later.
  task automatic cyc(input logic wr, input logic [7:0] d, input logic rd);
    bus.h_selectData = wr;
    bus.h_we_b       = ~wr;
    bus.h_data       = d;
    bus.p_selectData = rd;
    bus.p_rdnw       = 1'b1;
    @(posedge phi2);
    #1;
    bus.h_selectData = 1'b0;
    bus.h_we_b       = 1'b1;
    bus.p_selectData = 1'b0;
  endtask

  initial begin
    bus.h_selectData  = 1'b0;
    bus.h_we_b        = 1'b1;
    bus.h_data        = '0;
    bus.p_selectData  = 1'b0;
    bus.p_rdnw        = 1'b1;
    bus.one_byte_mode = 1'b0;
    bus.flush         = 1'b0;

    // Reset state
    repeat (2) @(posedge phi2);
    #1;
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_pdata", 32'(bus.p_data), 0);
    chk("rst_avail", 32'(bus.p_data_available), 0);
    chk("rst_full", 32'(bus.h_full), 0);
    chk("rst_burst", 32'(bus.p_burst_available), 0);
    chk("rst_ovf", 32'(bus.h_overflow), 0);
    chk("rst_unf", 32'(bus.p_underflow), 0);
    rst = 1'b0;

    // Burst mode fill
    cyc(1, 8'h11, 0);
    chk("b1_avail", 32'(bus.p_data_available), 0);
    chk("b1_level", 32'(bus.level), 1);
    chk("b1_pdata", 32'(bus.p_data), 32'h11);
    cyc(1, 8'h22, 0);
    chk("b2_avail", 32'(bus.p_data_available), 1);
    chk("b2_burst", 32'(bus.p_burst_available), 1);
    chk("b2_full", 32'(bus.h_full), 0);
    cyc(1, 8'h33, 0);
    chk("b3_full", 32'(bus.h_full), 0);
    cyc(1, 8'h44, 0);
    chk("b4_full", 32'(bus.h_full), 1);
    chk("b4_level", 32'(bus.level), 4);
    chk("b4_ovf", 32'(bus.h_overflow), 0);
    cyc(1, 8'h55, 0);
    chk("b5_ovf", 32'(bus.h_overflow), 1);
    chk("b5_level", 32'(bus.level), 4);
    chk("b5_head", 32'(bus.p_data), 32'h11);

    // Drain
    cyc(0, 8'h00, 1);
    chk("r1_pdata", 32'(bus.p_data), 32'h22);
    chk("r1_avail", 32'(bus.p_data_available), 1);
    chk("r1_full", 32'(bus.h_full), 1);
    chk("r1_level", 32'(bus.level), 3);
    cyc(0, 8'h00, 1);
    chk("r2_pdata", 32'(bus.p_data), 32'h33);
    chk("r2_burst", 32'(bus.p_burst_available), 1);
    cyc(0, 8'h00, 1);
    chk("r3_pdata", 32'(bus.p_data), 32'h44);
    chk("r3_avail", 32'(bus.p_data_available), 1);
    chk("r3_full", 32'(bus.h_full), 1);
    chk("r3_burst", 32'(bus.p_burst_available), 0);
    cyc(0, 8'h00, 1);
    chk("r4_avail", 32'(bus.p_data_available), 0);
    chk("r4_full", 32'(bus.h_full), 0);
    chk("r4_level", 32'(bus.level), 0);
    chk("r4_unf", 32'(bus.p_underflow), 0);
    cyc(0, 8'h00, 1);
    chk("r5_unf", 32'(bus.p_underflow), 1);
    chk("r5_level", 32'(bus.level), 0);

    // Simultaneous push and pop at level 2
    cyc(1, 8'hAA, 0);
    cyc(1, 8'hBB, 0);
    chk("pp_pre_level", 32'(bus.level), 2);
    cyc(1, 8'hCC, 1);
    chk("pp_level", 32'(bus.level), 2);
    chk("pp_pdata", 32'(bus.p_data), 32'hBB);
    chk("pp_avail", 32'(bus.p_data_available), 1);
    chk("pp_full", 32'(bus.h_full), 0);
    cyc(0, 8'h00, 1);
    chk("pp_r1_pdata", 32'(bus.p_data), 32'hCC);
    chk("pp_r1_avail", 32'(bus.p_data_available), 1);
    cyc(0, 8'h00, 1);
    chk("pp_r2_level", 32'(bus.level), 0);
    chk("pp_r2_avail", 32'(bus.p_data_available), 0);

    // Flush with a concurrent write, level 3, both errors set
    cyc(1, 8'h01, 0);
    cyc(1, 8'h02, 0);
    cyc(1, 8'h03, 0);
    chk("fl_pre_level", 32'(bus.level), 3);
    chk("fl_pre_ovf", 32'(bus.h_overflow), 1);
    chk("fl_pre_unf", 32'(bus.p_underflow), 1);
    bus.flush = 1'b1;
    cyc(1, 8'h04, 0);
    bus.flush = 1'b0;
    chk("fl_level", 32'(bus.level), 0);
    chk("fl_pdata", 32'(bus.p_data), 0);
    chk("fl_avail", 32'(bus.p_data_available), 0);
    chk("fl_full", 32'(bus.h_full), 0);
    chk("fl_ovf", 32'(bus.h_overflow), 0);
    chk("fl_unf", 32'(bus.p_underflow), 0);

    // One-byte mode
    bus.one_byte_mode = 1'b1;
    cyc(1, 8'hA5, 0);
    chk("ob1_level", 32'(bus.level), 1);
    chk("ob1_avail", 32'(bus.p_data_available), 1);
    chk("ob1_full", 32'(bus.h_full), 1);
    chk("ob1_burst", 32'(bus.p_burst_available), 0);
    cyc(1, 8'h5A, 0);
    chk("ob2_level", 32'(bus.level), 1);
    chk("ob2_pdata", 32'(bus.p_data), 32'h5A);
    chk("ob2_ovf", 32'(bus.h_overflow), 0);
    cyc(0, 8'h00, 1);
    chk("ob3_avail", 32'(bus.p_data_available), 0);
    chk("ob3_full", 32'(bus.h_full), 0);
    chk("ob3_level", 32'(bus.level), 0);
    bus.one_byte_mode = 1'b0;

    // Async reset between edges mid-burst
    cyc(1, 8'h10, 0);
    cyc(1, 8'h20, 0);
    chk("ar_pre_level", 32'(bus.level), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_level", 32'(bus.level), 0);
    chk("ar_avail", 32'(bus.p_data_available), 0);
    chk("ar_pdata", 32'(bus.p_data), 0);
    chk("ar_burst", 32'(bus.p_burst_available), 0);
    #3;
    rst = 1'b0;
    cyc(1, 8'h77, 0);
    chk("ar_rec_level", 32'(bus.level), 1);
    chk("ar_rec_pdata", 32'(bus.p_data), 32'h77);
    cyc(1, 8'h78, 0);
    chk("ar_rec_avail", 32'(bus.p_data_available), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
